// File: rtl/pc_next_select.sv
// Registered next-PC selector with NUM_SRC prioritised redirect sources and a one-entry pending buffer.
// Latency: a redirect sampled at edge N is visible on pc after edge N; no combinational src_req->pc path.
// Backpressure: stall holds pc; a redirect arriving during stall is parked in the buffer (lower index wins).
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   src_addr        flattened targets, source i at [i*LENGTH +: LENGTH]
//   src_req         per-source redirect request (level)
//   stall           hold pc this edge
//   pc              current PC (registered)
//   redirect_valid  pc was loaded from a redirect on the last edge
//   redirect_src    one-hot source of that redirect, zero otherwise
//   pend_valid      pending-redirect buffer occupied
module pc_next_select #(
    parameter int unsigned       LENGTH    = 32,
    parameter int unsigned       NUM_SRC   = 3,
    parameter logic [LENGTH-1:0] RESET_VAL = '0,
    parameter int unsigned       STEP      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*LENGTH-1:0]   src_addr,
    input  logic [NUM_SRC-1:0]          src_req,
    input  logic                        stall,
    output logic [LENGTH-1:0]           pc,
    output logic                        redirect_valid,
    output logic [NUM_SRC-1:0]          redirect_src,
    output logic                        pend_valid
);

    localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [IDXW-1:0]   pend_idx;
    logic [LENGTH-1:0] pend_addr;

    // Priority encoder: walk from the highest index down so the lowest set index is left standing.
    logic              new_vld;
    logic [IDXW-1:0]   new_idx;
    logic [LENGTH-1:0] new_addr;

    always_comb begin
        new_vld  = 1'b0;
        new_idx  = '0;
        new_addr = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_req[i]) begin
                new_vld  = 1'b1;
                new_idx  = IDXW'(i);
                new_addr = src_addr[i*LENGTH +: LENGTH];
            end
        end
    end

    // On an index tie the fresh request wins, so its address supersedes the parked one.
    logic new_beats_pend;
    assign new_beats_pend = new_vld && (!pend_valid || (new_idx <= pend_idx));

    logic              cand_vld;
    logic [IDXW-1:0]   cand_idx;
    logic [LENGTH-1:0] cand_addr;
    logic [NUM_SRC-1:0] cand_onehot;
    logic [LENGTH-1:0] pc_inc;

    assign cand_vld    = new_beats_pend || pend_valid;
    assign cand_idx    = new_beats_pend ? new_idx  : pend_idx;
    assign cand_addr   = new_beats_pend ? new_addr : pend_addr;
    assign cand_onehot = NUM_SRC'(1) << cand_idx;
    // Carry out of the adder is dropped so the PC wraps modulo 2^LENGTH.
    assign pc_inc      = pc + LENGTH'(STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc             <= RESET_VAL;
            redirect_valid <= 1'b0;
            redirect_src   <= '0;
            pend_valid     <= 1'b0;
            pend_idx       <= '0;
            pend_addr      <= '0;
        end else if (stall) begin
            redirect_valid <= 1'b0;
            redirect_src   <= '0;
            if (new_beats_pend) begin
                pend_valid <= 1'b1;
                pend_idx   <= new_idx;
                pend_addr  <= new_addr;
            end
        end else if (cand_vld) begin
            // Whichever candidate is taken, the buffer is emptied; a losing parked entry is discarded.
            pc             <= cand_addr;
            redirect_valid <= 1'b1;
            redirect_src   <= cand_onehot;
            pend_valid     <= 1'b0;
        end else begin
            pc             <= pc_inc;
            redirect_valid <= 1'b0;
            redirect_src   <= '0;
        end
    end

endmodule

// File: tb/tb_pc_next_select.sv
module tb_pc_next_select;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [95:0] src_addr = '0;
    logic [2:0]  src_req = '0;
    logic        stall = 1'b0;
    logic [31:0] pc;
    logic        redirect_valid;
    logic [2:0]  redirect_src;
    logic        pend_valid;

    int n_cmp = 0;
    int n_err = 0;

    pc_next_select #(.LENGTH(32), .NUM_SRC(3), .RESET_VAL(32'h0), .STEP(4)) dut (
        .clk(clk), .rst(rst), .src_addr(src_addr), .src_req(src_req), .stall(stall),
        .pc(pc), .redirect_valid(redirect_valid), .redirect_src(redirect_src),
        .pend_valid(pend_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the PC as an integer, the buffer as an (index, address) pair.
    int unsigned m_pc;
    bit          m_rv;
    int          m_src;      // -1 means no redirect
    bit          m_pv;
    int          m_pidx;
    int unsigned m_paddr;

    always @(posedge clk or posedge rst) begin
        int nw;
        if (rst) begin
            m_pc = 0; m_rv = 0; m_src = -1; m_pv = 0; m_pidx = 0; m_paddr = 0;
        end else begin
            nw = -1;
            for (int i = 2; i >= 0; i--) if (src_req[i]) nw = i;
            if (stall) begin
                m_rv = 0; m_src = -1;
                if (nw >= 0 && (!m_pv || nw <= m_pidx)) begin
                    m_pv = 1; m_pidx = nw; m_paddr = src_addr[nw*32 +: 32];
                end
            end else begin
                // Choose the smaller index among {new, pending}; the new one wins a tie.
                if (nw >= 0 && (!m_pv || nw <= m_pidx)) begin
                    m_pc = src_addr[nw*32 +: 32]; m_rv = 1; m_src = nw;
                end else if (m_pv) begin
                    m_pc = m_paddr; m_rv = 1; m_src = m_pidx;
                end else begin
                    m_pc = m_pc + 4; m_rv = 0; m_src = -1;
                end
                m_pv = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("model_pc", pc, m_pc);
        check("model_rv", {31'b0, redirect_valid}, {31'b0, m_rv});
        check("model_src", {29'b0, redirect_src}, (m_src < 0) ? 32'h0 : (32'h1 << m_src));
        check("model_pv", {31'b0, pend_valid}, {31'b0, m_pv});
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] r, input int unsigned a0, input int unsigned a1,
                       input int unsigned a2);
        src_req  = r;
        src_addr = {a2, a1, a0};
    endtask

    initial begin
        @(negedge clk); #1;
        tick();
        rst = 1'b0;
        check("rst_pc", pc, 32'h0);
        check("rst_rv", {31'b0, redirect_valid}, 32'h0);
        check("rst_pv", {31'b0, pend_valid}, 32'h0);
        tick(); check("run_pc1", pc, 32'h4);
        tick(); check("run_pc2", pc, 32'h8);
        tick(); check("run_pc3", pc, 32'hC);
        check("run_rv", {31'b0, redirect_valid}, 32'h0);

        // Reset asserted between edges must clear pc at once.
        #3 rst = 1'b1;
        #1 check("async_rst_pc", pc, 32'h0);
        @(negedge clk); #1 rst = 1'b0;
        repeat (4) tick();
        check("pre_sim_pc", pc, 32'h10);

        req(3'b110, 0, 32'h100, 32'h200);
        tick();
        check("sim_pc", pc, 32'h100);
        check("sim_src", {29'b0, redirect_src}, 32'h2);
        check("sim_rv", {31'b0, redirect_valid}, 32'h1);
        req(3'b000, 0, 0, 0);
        tick();
        check("sim_next_pc", pc, 32'h104);
        check("sim_next_rv", {31'b0, redirect_valid}, 32'h0);

        req(3'b001, 32'h20, 0, 0);
        tick();
        stall = 1'b1;
        req(3'b100, 0, 0, 32'h300);
        tick();
        req(3'b000, 0, 0, 0);
        tick(); tick();
        check("stall_pc", pc, 32'h20);
        check("stall_pv", {31'b0, pend_valid}, 32'h1);
        stall = 1'b0;
        tick();
        check("rel_pc", pc, 32'h300);
        check("rel_src", {29'b0, redirect_src}, 32'h4);
        check("rel_pv", {31'b0, pend_valid}, 32'h0);

        stall = 1'b1;
        req(3'b100, 0, 0, 32'h300); tick();
        req(3'b001, 32'h40, 0, 0);  tick();
        req(3'b010, 0, 32'h500, 0); tick();
        check("prio_pc_hold", pc, 32'h300);
        check("prio_pv", {31'b0, pend_valid}, 32'h1);
        req(3'b000, 0, 0, 0);
        stall = 1'b0;
        tick();
        check("prio_pc", pc, 32'h40);
        check("prio_src", {29'b0, redirect_src}, 32'h1);

        stall = 1'b1;
        req(3'b010, 0, 32'h500, 0); tick();
        stall = 1'b0;
        req(3'b001, 32'h80, 0, 0);  tick();
        check("pvn_pc", pc, 32'h80);
        check("pvn_src", {29'b0, redirect_src}, 32'h1);
        check("pvn_pv", {31'b0, pend_valid}, 32'h0);

        req(3'b001, 32'hFFFF_FFFC, 0, 0); tick();
        check("wrap_tgt", pc, 32'hFFFF_FFFC);
        req(3'b000, 0, 0, 0);
        tick(); check("wrap_pc0", pc, 32'h0);
        tick(); check("wrap_pc4", pc, 32'h4);

        // Random phase, the per-cycle compare process does the checking.
        for (int c = 0; c < 3000; c++) begin
            stall   = ($urandom_range(0, 3) == 0);
            src_req = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            src_addr = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #1 check("rand_async_rst", pc, 32'h0);
                @(negedge clk); #1 rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
